int_sequencer: RTL and testbench
================================

INT_SEQUENCER -- requirements
Module: int_sequencer

Interface
REQ-001 SHALL have parameter VEC_BASE, default 32'h0000_0100, handler vector of level 1.
REQ-002 SHALL have parameter VEC_STRIDE, default 32'h0000_0010, address step between level vectors.
REQ-003 in_CLK  input  1  sole clock, all state on rising edge.
REQ-004 in_RST  input  1  reset, asynchronous, active-high.
REQ-005 in_code  input  2  encoded pending level from the interrupt controller (0 = none, 3 = highest).
REQ-006 in_break  input  1  controller request to enter a handler.
REQ-007 in_PC  input  32  return address of the interrupted instruction.
REQ-008 in_eret  input  1  handler-return instruction strobe, one cycle.
REQ-009 in_sti / in_cli  input  1 each  set / clear global interrupt enable.
REQ-010 out_IG  output  4  one-cycle grant pulses that clear controller request bits.
REQ-011 out_INM  output  4  level mask to the controller; bit3 SHALL be constant 0.
REQ-012 out_IE  output  1  global enable to the controller.
REQ-013 out_take  output  1  one-cycle PC-load strobe.
REQ-014 out_target  output  32  PC value loaded when out_take=1, else 0.
REQ-015 out_depth  output  2  current nesting depth, 0..3.
REQ-016 out_err  output  1  one-cycle pulse on illegal eret.

Function
REQ-017 SHALL implement FSM states IDLE, ENTER, VECTOR, RETURN; ENTER, VECTOR and RETURN SHALL each last exactly one cycle.
REQ-018 In IDLE, in_eret=1 with depth>0 SHALL go to RETURN; this takes priority over in_break in the same cycle.
REQ-019 In IDLE, in_break=1 with in_code!=0, depth<3 and no eret SHALL go to ENTER, capturing the code as L.
REQ-020 in_break=1 with in_code=0, or with depth=3, SHALL be ignored with no state change.
REQ-021 ENTER SHALL push {in_PC, out_INM} onto a 3-entry LIFO and increment depth.
REQ-022 ENTER SHALL assert out_IG[L-1] for that cycle only, with all other out_IG bits 0.
REQ-023 ENTER SHALL clear out_IE.
REQ-024 ENTER SHALL set out_INM[2:0] so that bits 0..L-1 are 1 and bits L..2 are 0; same-or-lower levels are masked, higher levels stay open.
REQ-025 VECTOR SHALL assert out_take=1 with out_target = VEC_BASE + (L-1)*VEC_STRIDE, computed modulo 2^32.
REQ-026 VECTOR SHALL set out_IE=1 and return to IDLE, so nesting is possible from the next cycle.
REQ-027 Break-to-out_take latency SHALL be 2 cycles: ENTER then VECTOR.
REQ-028 RETURN SHALL pop the LIFO, assert out_take=1 with out_target = popped PC, restore out_INM to the popped mask, set out_IE=1, decrement depth, and go to IDLE.
REQ-029 in_eret=1 with depth=0 SHALL pulse out_err for one cycle and change nothing else.
REQ-030 In IDLE with no transition, in_cli SHALL clear out_IE and in_sti SHALL set it; if both are 1, in_cli wins.
REQ-031 in_sti and in_cli SHALL be ignored in ENTER, VECTOR and RETURN.
REQ-032 in_eret and in_break SHALL be ignored in ENTER, VECTOR and RETURN; the controller keeps requests latched, so they re-evaluate in IDLE.
REQ-033 A LIFO entry SHALL be written only in ENTER and read only in RETURN; it SHALL never overflow or underflow.
REQ-034 out_IG, out_take and out_err SHALL be registered and glitch-free.

Reset
REQ-035 in_RST=1 SHALL, asynchronously, force state IDLE, depth 0, out_IE=0, out_INM=0, out_IG=0, out_take=0, out_target=0, out_err=0.
REQ-036 Reset in any state, including ENTER, VECTOR or RETURN, SHALL abort the sequence with no grant or take pulse afterwards.
REQ-037 LIFO contents need not be cleared on reset, but SHALL be unreadable while depth=0.

Verification
REQ-038 Single entry: sti; code=2, break=1, PC=0x40 -> next cycle out_IG=0010, out_INM=0011, IE=0 -> next cycle take=1, target=0x110, IE=1, depth=1.
REQ-039 Nested: in level-1 handler with PC=0x104, code=3, break -> target=0x120, INM=0111, depth=2; eret -> target=0x104, INM=0001, depth=1; eret -> target = original PC, INM=0000, depth=0.
REQ-040 Simultaneous: depth=1, eret=1 and break=1 with code=3 in the same cycle -> RETURN taken first, then ENTER for level 3 on the following IDLE cycle if break is still high.
REQ-041 Illegal: depth=0, eret=1 -> out_err=1 for one cycle, out_take=0, state unchanged.
REQ-042 Reset in ENTER: assert in_RST during ENTER -> all outputs 0 immediately, no VECTOR take, depth=0; sti and break after release -> normal entry.
REQ-043 Enable: sti and cli together in IDLE -> out_IE=0; break with code=0 -> no grant pulse.

Source files
------------

// File: rtl/int_sequencer_if.sv
// Bundle between the interrupt controller / CPU pipeline and the interrupt sequencer.
// The master side drives requests and strobes; the slave (sequencer) side drives grants, mask and PC loads.
interface int_sequencer_if;
  logic [1:0]  in_code;
  logic        in_break;
  logic [31:0] in_PC;
  logic        in_eret;
  logic        in_sti;
  logic        in_cli;
  logic [3:0]  out_IG;
  logic [3:0]  out_INM;
  logic        out_IE;
  logic        out_take;
  logic [31:0] out_target;
  logic [1:0]  out_depth;
  logic        out_err;

  modport master (
    output in_code, in_break, in_PC, in_eret, in_sti, in_cli,
    input  out_IG, out_INM, out_IE, out_take, out_target, out_depth, out_err
  );

  modport slave (
    input  in_code, in_break, in_PC, in_eret, in_sti, in_cli,
    output out_IG, out_INM, out_IE, out_take, out_target, out_depth, out_err
  );
endinterface

// File: rtl/int_sequencer.sv
// Nested interrupt entry/return sequencer: grants a level, vectors the PC and
// keeps a 3-deep stack of {return PC, level mask} for eret.
module int_sequencer #(
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic             in_CLK,
  input  logic             in_RST,
  int_sequencer_if.slave   bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTER  = 2'd1,
    VECTOR = 2'd2,
    RETURN = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  lvl;
  logic [1:0]  depth;
  logic [1:0]  top;
  logic        ie;
  logic [2:0]  inm;
  logic [3:0]  ig;
  logic        take;
  logic [31:0] target;
  logic        err;

  logic [31:0] pc_mem   [3];
  logic [2:0]  mask_mem [3];

  logic do_ret;
  logic do_err;
  logic do_ent;

  assign top    = depth - 2'd1;
  assign do_ret = bus.in_eret && (depth != 2'd0);
  assign do_err = bus.in_eret && (depth == 2'd0);
  assign do_ent = bus.in_break && !bus.in_eret && (bus.in_code != 2'd0) && (depth != 2'd3);

  // Stack storage needs no reset: it is only read when depth > 0.
  always_ff @(posedge in_CLK) begin
    if (state == IDLE && do_ent) begin
      pc_mem[depth]   <= bus.in_PC;
      mask_mem[depth] <= inm;
    end
  end

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      state  <= IDLE;
      lvl    <= 2'd0;
      depth  <= 2'd0;
      ie     <= 1'b0;
      inm    <= 3'd0;
      ig     <= 4'd0;
      take   <= 1'b0;
      target <= 32'd0;
      err    <= 1'b0;
    end else begin
      ig     <= 4'd0;
      take   <= 1'b0;
      target <= 32'd0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (do_ret) begin
            state  <= RETURN;
            take   <= 1'b1;
            target <= pc_mem[top];
            inm    <= mask_mem[top];
            ie     <= 1'b1;
            depth  <= top;
          end else if (do_err) begin
            err <= 1'b1;
          end else if (do_ent) begin
            state <= ENTER;
            lvl   <= bus.in_code;
            ig    <= 4'b0001 << (bus.in_code - 2'd1);
            ie    <= 1'b0;
            // Mask own level and below; higher levels stay open for nesting.
            inm   <= {bus.in_code == 2'd3, bus.in_code >= 2'd2, 1'b1};
            depth <= depth + 2'd1;
          end else if (bus.in_cli) begin
            ie <= 1'b0;
          end else if (bus.in_sti) begin
            ie <= 1'b1;
          end
        end
        ENTER: begin
          state  <= VECTOR;
          take   <= 1'b1;
          target <= VEC_BASE + VEC_STRIDE * {30'd0, lvl - 2'd1};
          ie     <= 1'b1;
        end
        VECTOR:  state <= IDLE;
        RETURN:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_IG     = ig;
  assign bus.out_INM    = {1'b0, inm};
  assign bus.out_IE     = ie;
  assign bus.out_take   = take;
  assign bus.out_target = target;
  assign bus.out_depth  = depth;
  assign bus.out_err    = err;
  assign dbg_state      = state;

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: entry, nesting, simultaneous eret/break,
// illegal eret, enable control, depth limit and reset during ENTER.
module tb_int_sequencer;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ENTER  = 2'd1;
  localparam logic [1:0] S_VECTOR = 2'd2;
  localparam logic [1:0] S_RETURN = 2'd3;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;

  int_sequencer_if bus ();

  int_sequencer #(
    .VEC_BASE   (32'h0000_0100),
    .VEC_STRIDE (32'h0000_0010)
  ) dut (
    .in_CLK    (clk),
    .in_RST    (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_code  = 2'd0;
    bus.in_break = 1'b0;
    bus.in_eret  = 1'b0;
    bus.in_sti   = 1'b0;
    bus.in_cli   = 1'b0;
  endtask

  // Full entry: break cycle, ENTER cycle, VECTOR cycle, back in IDLE.
  task automatic do_entry(input string tag, input logic [1:0] code, input logic [31:0] pc,
                          input logic [3:0] exp_ig, input logic [3:0] exp_inm,
                          input logic [31:0] exp_target, input logic [1:0] exp_depth);
    bus.in_code  = code;
    bus.in_break = 1'b1;
    bus.in_PC    = pc;
    step();
    idle_inputs();
    check({tag, "_enter_state"}, 32'(dbg_state), 32'(S_ENTER));
    check({tag, "_ig"},          32'(bus.out_IG), 32'(exp_ig));
    check({tag, "_inm"},         32'(bus.out_INM), 32'(exp_inm));
    check({tag, "_ie_low"},      32'(bus.out_IE), 32'd0);
    check({tag, "_depth"},       32'(bus.out_depth), 32'(exp_depth));
    step();
    check({tag, "_take"},        32'(bus.out_take), 32'd1);
    check({tag, "_target"},      bus.out_target, exp_target);
    check({tag, "_ie_high"},     32'(bus.out_IE), 32'd1);
    check({tag, "_ig_clear"},    32'(bus.out_IG), 32'd0);
    step();
    check({tag, "_idle"},        32'(dbg_state), 32'(S_IDLE));
    check({tag, "_take_clear"},  32'(bus.out_take), 32'd0);
  endtask

  task automatic do_return(input string tag, input logic [31:0] exp_target,
                           input logic [3:0] exp_inm, input logic [1:0] exp_depth);
    bus.in_eret = 1'b1;
    step();
    bus.in_eret = 1'b0;
    check({tag, "_state"},  32'(dbg_state), 32'(S_RETURN));
    check({tag, "_take"},   32'(bus.out_take), 32'd1);
    check({tag, "_target"}, bus.out_target, exp_target);
    check({tag, "_inm"},    32'(bus.out_INM), 32'(exp_inm));
    check({tag, "_depth"},  32'(bus.out_depth), 32'(exp_depth));
    check({tag, "_ie"},     32'(bus.out_IE), 32'd1);
    step();
    check({tag, "_idle"},   32'(dbg_state), 32'(S_IDLE));
    check({tag, "_take0"},  32'(bus.out_take), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"},  32'(dbg_state), 32'(S_IDLE));
    check({tag, "_depth"},  32'(bus.out_depth), 32'd0);
    check({tag, "_ie"},     32'(bus.out_IE), 32'd0);
    check({tag, "_inm"},    32'(bus.out_INM), 32'd0);
    check({tag, "_ig"},     32'(bus.out_IG), 32'd0);
    check({tag, "_take"},   32'(bus.out_take), 32'd0);
    check({tag, "_target"}, bus.out_target, 32'd0);
    check({tag, "_err"},    32'(bus.out_err), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    bus.in_PC = 32'd0;
    rst = 1'b1;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check_all_zero("post_reset");

    // Single entry at level 2 and return.
    bus.in_sti = 1'b1;
    step();
    bus.in_sti = 1'b0;
    check("sti_ie", 32'(bus.out_IE), 32'd1);
    do_entry("single", 2'd2, 32'h40, 4'b0010, 4'b0011, 32'h110, 2'd1);
    do_return("single_ret", 32'h40, 4'b0000, 2'd0);

    // Nested: level 1 then level 3, unwound by two erets.
    do_entry("nest1", 2'd1, 32'h200, 4'b0001, 4'b0001, 32'h100, 2'd1);
    do_entry("nest3", 2'd3, 32'h104, 4'b0100, 4'b0111, 32'h120, 2'd2);
    do_return("nest_ret1", 32'h104, 4'b0001, 2'd1);
    do_return("nest_ret0", 32'h200, 4'b0000, 2'd0);

    // eret and break in the same cycle: RETURN first, then ENTER.
    do_entry("sim_pre", 2'd1, 32'h300, 4'b0001, 4'b0001, 32'h100, 2'd1);
    bus.in_eret  = 1'b1;
    bus.in_break = 1'b1;
    bus.in_code  = 2'd3;
    bus.in_PC    = 32'h50;
    step();
    bus.in_eret = 1'b0;
    check("sim_ret_state",  32'(dbg_state), 32'(S_RETURN));
    check("sim_ret_target", bus.out_target, 32'h300);
    check("sim_ret_ig",     32'(bus.out_IG), 32'd0);
    check("sim_ret_depth",  32'(bus.out_depth), 32'd0);
    step();
    check("sim_idle",       32'(dbg_state), 32'(S_IDLE));
    step();
    idle_inputs();
    check("sim_enter",      32'(dbg_state), 32'(S_ENTER));
    check("sim_enter_ig",   32'(bus.out_IG), 32'b0100);
    check("sim_enter_inm",  32'(bus.out_INM), 32'b0111);
    step();
    check("sim_vec_target", bus.out_target, 32'h120);
    step();
    do_return("sim_ret2", 32'h50, 4'b0000, 2'd0);

    // Illegal eret at depth 0.
    bus.in_eret = 1'b1;
    step();
    bus.in_eret = 1'b0;
    check("illegal_err",   32'(bus.out_err), 32'd1);
    check("illegal_take",  32'(bus.out_take), 32'd0);
    check("illegal_state", 32'(dbg_state), 32'(S_IDLE));
    check("illegal_ie",    32'(bus.out_IE), 32'd1);
    step();
    check("illegal_err_clear", 32'(bus.out_err), 32'd0);

    // sti + cli together: cli wins. break with code 0 is ignored.
    bus.in_sti = 1'b1;
    bus.in_cli = 1'b1;
    step();
    idle_inputs();
    check("stcli_ie", 32'(bus.out_IE), 32'd0);
    bus.in_break = 1'b1;
    bus.in_code  = 2'd0;
    step();
    idle_inputs();
    check("code0_ig",    32'(bus.out_IG), 32'd0);
    check("code0_state", 32'(dbg_state), 32'(S_IDLE));
    check("code0_depth", 32'(bus.out_depth), 32'd0);

    // Fill the stack, then a break at depth 3 must be ignored.
    do_entry("fill1", 2'd1, 32'h1000, 4'b0001, 4'b0001, 32'h100, 2'd1);
    do_entry("fill2", 2'd2, 32'h2000, 4'b0010, 4'b0011, 32'h110, 2'd2);
    do_entry("fill3", 2'd3, 32'h3000, 4'b0100, 4'b0111, 32'h120, 2'd3);
    bus.in_break = 1'b1;
    bus.in_code  = 2'd3;
    step();
    idle_inputs();
    check("full_state", 32'(dbg_state), 32'(S_IDLE));
    check("full_ig",    32'(bus.out_IG), 32'd0);
    check("full_depth", 32'(bus.out_depth), 32'd3);
    do_return("unwind3", 32'h3000, 4'b0011, 2'd2);
    do_return("unwind2", 32'h2000, 4'b0001, 2'd1);
    do_return("unwind1", 32'h1000, 4'b0000, 2'd0);

    // Reset asserted while in ENTER aborts the sequence.
    bus.in_code  = 2'd2;
    bus.in_break = 1'b1;
    bus.in_PC    = 32'h60;
    step();
    idle_inputs();
    check("rst_enter_state", 32'(dbg_state), 32'(S_ENTER));
    rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    step();
    rst = 1'b0;
    step();
    check_all_zero("rst_after");
    bus.in_sti = 1'b1;
    step();
    bus.in_sti = 1'b0;
    do_entry("after_rst", 2'd2, 32'h70, 4'b0010, 4'b0011, 32'h110, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
